// File: rtl/div_req_arbiter.sv
// div_req_arbiter: round-robin front end sharing one pipelined divider
// between NREQ requesters. A tag pipeline of LAT stages tracks the owner
// of each in-flight divide and steers the result back as a one-cycle
// registered response.
// Optional feature: define DIV_ARB_ZERO_CHECK_EN to short-circuit divide
// by zero without using the divider (quotient all ones, rsp_err=1).
module div_req_arbiter #(
    parameter int N    = 5,
    parameter int M    = 3,
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*M-1:0] req_divisor,
    output logic [NREQ-1:0]   req_ready,
    output logic              div_data_rdy,
    output logic [N-1:0]      div_dividend,
    output logic [M-1:0]      div_divisor,
    input  logic              div_res_rdy,
    input  logic [N-1:0]      div_merchant,
    input  logic [M-1:0]      div_remainder,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_quot,
    output logic [M-1:0]      rsp_rem,
    output logic              rsp_err,
    output logic              busy,
    output logic              sync_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] own;
`ifdef DIV_ARB_ZERO_CHECK_EN
        logic          zdiv;
`endif
    } tag_t;

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] cand;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic [N-1:0]  grant_dividend;
    logic [M-1:0]  grant_divisor;

    logic          div_data_rdy_q, div_data_rdy_d;
    logic [N-1:0]  div_dividend_q, div_dividend_d;
    logic [M-1:0]  div_divisor_q, div_divisor_d;
    tag_t          itag_q, itag_d;
    tag_t          tag_q [LAT];
    tag_t          tag_d [LAT];
    tag_t          head;
    logic          head_zdiv;

    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [N-1:0]    rsp_quot_q, rsp_quot_d;
    logic [M-1:0]    rsp_rem_q, rsp_rem_d;
    logic            rsp_err_q, rsp_err_d;
    logic            sync_err_q, sync_err_d;

    // Round-robin search starting one past the last winner
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!rst && !hold) begin
            for (int unsigned k = 1; k <= unsigned'(NREQ); k++) begin
                cand = IW'((int'(last_q) + int'(k)) % NREQ);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    assign grant_dividend = req_dividend[grant_idx*N +: N];
    assign grant_divisor  = req_divisor[grant_idx*M +: M];

    // Pointer, issue register and tag pipeline next-state
    always_comb begin
        last_d         = grant_any ? grant_idx : last_q;
        div_data_rdy_d = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        itag_d         = '0;
        if (grant_any) begin
            div_dividend_d = grant_dividend;
            div_divisor_d  = grant_divisor;
            itag_d.vld     = 1'b1;
            itag_d.own     = grant_idx;
`ifdef DIV_ARB_ZERO_CHECK_EN
            if (grant_divisor == '0) begin
                itag_d.zdiv = 1'b1;
            end else begin
                div_data_rdy_d = 1'b1;
            end
`else
            div_data_rdy_d = 1'b1;
`endif
        end
        tag_d[0] = itag_q;
        for (int unsigned k = 1; k < unsigned'(LAT); k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign head = tag_q[LAT-1];
`ifdef DIV_ARB_ZERO_CHECK_EN
    assign head_zdiv = head.zdiv;
`else
    assign head_zdiv = 1'b0;
`endif

    // Response steering from the head tag; payload holds when idle
    always_comb begin
        rsp_valid_d = '0;
        rsp_quot_d  = rsp_quot_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_err_d   = rsp_err_q;
        sync_err_d  = sync_err_q;
        if (head.vld) begin
            rsp_valid_d[head.own] = 1'b1;
            if (head_zdiv) begin
                rsp_quot_d = '1;
                rsp_rem_d  = '0;
                rsp_err_d  = 1'b1;
            end else begin
                rsp_quot_d = div_merchant;
                rsp_rem_d  = div_remainder;
                rsp_err_d  = !div_res_rdy;
                if (!div_res_rdy) begin
                    sync_err_d = 1'b1;
                end
            end
        end
    end

    // Activity: anything issued, in flight or being answered
    always_comb begin
        busy = div_data_rdy_q | itag_q.vld | (|rsp_valid_q);
        for (int unsigned k = 0; k < unsigned'(LAT); k++) begin
            busy = busy | tag_q[k].vld;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q         <= IW'(NREQ - 1);
            div_data_rdy_q <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            itag_q         <= '0;
            for (int unsigned k = 0; k < unsigned'(LAT); k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q    <= '0;
            rsp_quot_q     <= '0;
            rsp_rem_q      <= '0;
            rsp_err_q      <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            last_q         <= last_d;
            div_data_rdy_q <= div_data_rdy_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            itag_q         <= itag_d;
            for (int unsigned k = 0; k < unsigned'(LAT); k++) begin
                tag_q[k] <= tag_d[k];
            end
            rsp_valid_q    <= rsp_valid_d;
            rsp_quot_q     <= rsp_quot_d;
            rsp_rem_q      <= rsp_rem_d;
            rsp_err_q      <= rsp_err_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign div_data_rdy = div_data_rdy_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_quot     = rsp_quot_q;
    assign rsp_rem      = rsp_rem_q;
    assign rsp_err      = rsp_err_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_div_req_arbiter.sv
// Bench for div_req_arbiter (default build, zero check disabled).
// Contains a pipelined divider stand-in with optional rdy suppression and a
// schedule-based reference model of grants, responses, busy and sync_err.
module tb_div_req_arbiter;

    localparam int N    = 5;
    localparam int M    = 3;
    localparam int NREQ = 2;
    localparam int LAT  = 2;

    logic              clk;
    logic              rst;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_dividend;
    logic [NREQ*M-1:0] req_divisor;
    logic [NREQ-1:0]   req_ready;
    logic              div_data_rdy;
    logic [N-1:0]      div_dividend;
    logic [M-1:0]      div_divisor;
    logic              div_res_rdy;
    logic [N-1:0]      div_merchant;
    logic [M-1:0]      div_remainder;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_quot;
    logic [M-1:0]      rsp_rem;
    logic              rsp_err;
    logic              busy;
    logic              sync_err;

    div_req_arbiter #(.N(N), .M(M), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready),
        .div_data_rdy(div_data_rdy), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_res_rdy(div_res_rdy), .div_merchant(div_merchant), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
        .busy(busy), .sync_err(sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider stand-in: result LAT cycles after the issue strobe; one armed
    // operation has its rdy suppressed while its data still passes through.
    bit [LAT-1:0] dv;
    logic [N-1:0] dq [LAT];
    logic [M-1:0] dr [LAT];
    int arm_req  = 0;
    int arm_done = 0;

    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            dv[k] <= dv[k-1];
            dq[k] <= dq[k-1];
            dr[k] <= dr[k-1];
        end
        dv[0] <= div_data_rdy && (arm_req == arm_done);
        if (div_data_rdy && (arm_req != arm_done)) arm_done <= arm_done + 1;
        if (div_divisor == '0) begin
            dq[0] <= '1;
            dr[0] <= div_dividend[M-1:0];
        end else begin
            dq[0] <= N'(div_dividend / N'(div_divisor));
            dr[0] <= M'(div_dividend % N'(div_divisor));
        end
    end

    assign div_res_rdy   = dv[LAT-1];
    assign div_merchant  = dq[LAT-1];
    assign div_remainder = dr[LAT-1];

    // Reference model state
    typedef struct {
        bit v;
        int own;
        int q;
        int r;
        bit e;
    } rsp_t;

    rsp_t sched [64];
    int   cyc    = 0;
    int   last_m = NREQ - 1;
    int   lg     = -1000;
    int   pq = 0, pr = 0;
    bit   pe = 1'b0, psync = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        bit       h;
        bit [1:0] v;
        int       a0, b0, a1, b1;
        bit [1:0] rdy;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model
    task automatic step(input bit r, input bit h, input bit [1:0] v,
                        input int a0, input int b0, input int a1, input int b1,
                        input bit flt, input int tbl_rdy);
        int   g;
        int   aa, bb, q, rr;
        rsp_t e;
        rst          = r;
        hold         = h;
        req_valid    = v;
        req_dividend = {N'(a1), N'(a0)};
        req_divisor  = {M'(b1), M'(b0)};
        @(negedge clk);
        g = -1;
        if (!r && !h) begin
            for (int off = 1; off <= NREQ; off++) begin
                int i;
                i = (last_m + off) % NREQ;
                if (v[i]) begin
                    g = i;
                    break;
                end
            end
        end
        chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
        if (tbl_rdy >= 0) chk("tbl_ready", int'(req_ready), tbl_rdy);
        chk("div_data_rdy", int'(div_data_rdy), (cyc == lg + 1) ? 1 : 0);
        e = sched[cyc % 64];
        if (e.v) begin
            pq = e.q;
            pr = e.r;
            pe = e.e;
            if (e.e) psync = 1'b1;
        end
        chk("rsp_valid", int'(rsp_valid), e.v ? (1 << e.own) : 0);
        chk("rsp_quot", int'(rsp_quot), pq);
        chk("rsp_rem", int'(rsp_rem), pr);
        chk("rsp_err", int'(rsp_err), int'(pe));
        chk("sync_err", int'(sync_err), int'(psync));
        chk("busy", int'(busy), (cyc > lg && cyc <= lg + LAT + 2) ? 1 : 0);
        sched[cyc % 64].v = 1'b0;
        if (r) begin
            for (int k = 0; k < 64; k++) sched[k].v = 1'b0;
            last_m = NREQ - 1;
            lg     = -1000;
            pq     = 0;
            pr     = 0;
            pe     = 1'b0;
            psync  = 1'b0;
        end else if (g >= 0) begin
            aa = (g == 0) ? a0 : a1;
            bb = (g == 0) ? b0 : b1;
            aa = aa & ((1 << N) - 1);
            bb = bb & ((1 << M) - 1);
            if (bb == 0) begin
                q  = (1 << N) - 1;
                rr = aa % (1 << M);
            end else begin
                q  = aa / bb;
                rr = aa % bb;
            end
            // Suppression only targets an isolated issue so the armed slot is unambiguous
            if (flt && (lg != cyc - 1)) begin
                arm_req++;
                sched[(cyc + LAT + 2) % 64] = '{1'b1, g, q, rr, 1'b1};
            end else begin
                sched[(cyc + LAT + 2) % 64] = '{1'b1, g, q, rr, 1'b0};
            end
            last_m = g;
            lg     = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, -1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 2'b11, 20, 3, 7, 2, 2'b01};
        tbl[1] = '{1'b0, 2'b11, 20, 3, 7, 2, 2'b10};
        tbl[2] = '{1'b0, 2'b10, 11, 5, 30, 7, 2'b10};
        tbl[3] = '{1'b0, 2'b01, 31, 1, 4, 4, 2'b01};
        tbl[4] = '{1'b1, 2'b11, 12, 3, 12, 5, 2'b00};
        tbl[5] = '{1'b0, 2'b11, 12, 3, 25, 6, 2'b10};
        tbl[6] = '{1'b0, 2'b00, 0, 1, 0, 1, 2'b00};
        tbl[7] = '{1'b0, 2'b11, 17, 2, 5, 7, 2'b01};
        tbl[8] = '{1'b0, 2'b01, 9, 0, 3, 1, 2'b01};
        tbl[9] = '{1'b0, 2'b00, 0, 1, 0, 1, 2'b00};

        rst = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, -1);
        idle(2);

        // Arbitration table, including hold and a zero divisor
        for (int k = 0; k < 10; k++)
            step(1'b0, tbl[k].h, tbl[k].v, tbl[k].a0, tbl[k].b0, tbl[k].a1, tbl[k].b1,
                 1'b0, int'(tbl[k].rdy));
        idle(6);

        // Single op 13/3 from requester 0
        step(1'b0, 1'b0, 2'b01, 13, 3, 0, 1, 1'b0, -1);
        idle(6);

        // Contention: both valid for 6 cycles
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 2'b11, 20, 3, 7, 2, 1'b0, -1);
        idle(6);

        // Hold while requester 1 waits; busy drains during the hold
        step(1'b0, 1'b0, 2'b01, 29, 4, 0, 1, 1'b0, -1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 2'b10, 0, 1, 22, 5, 1'b0, -1);
        step(1'b0, 1'b0, 2'b11, 3, 1, 22, 5, 1'b0, 2'b10);
        idle(6);

        // Reset one cycle after two issues; stale divider results are dropped
        step(1'b0, 1'b0, 2'b01, 18, 4, 0, 1, 1'b0, -1);
        step(1'b0, 1'b0, 2'b10, 0, 1, 27, 6, 1'b0, -1);
        idle(1);
        step(1'b1, 1'b0, 2'b11, 5, 1, 5, 1, 1'b0, 2'b00);
        idle(6);

        // Sync fault on an isolated op; sticky until reset
        step(1'b0, 1'b0, 2'b01, 20, 3, 0, 1, 1'b1, -1);
        idle(6);
        step(1'b0, 1'b0, 2'b10, 0, 1, 7, 2, 1'b0, -1);
        idle(6);
        step(1'b1, 1'b0, 2'b00, 0, 1, 0, 1, 1'b0, -1);
        idle(2);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 19) == 0), -1);
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_req_arbiter.md
# div_req_arbiter

Front-end controller that shares one pipelined restoring divider (`N`-bit dividend, `M`-bit divisor, fixed result latency `LAT`) between `NREQ` requesters. Round-robin arbitration issues at most one division per cycle. A tag shift register tracks the owner of each in-flight operation and steers each divider result back to that requester as a registered one-cycle response. It sits between client blocks and the divider instance, and is the only agent that drives the divider's `data_rdy`.

## Interface
- `N`, 5: dividend / quotient width
- `M`, 3: divisor / remainder width
- `NREQ`, 2: number of requesters (2..8)
- `LAT`, 2: divider latency, from `div_data_rdy` high to `div_res_rdy` high (cycles)
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous reset, active high
- `hold` in 1: when 1, no new grants are issued; in-flight operations drain
- `req_valid` in NREQ: per-requester request
- `req_dividend` in NREQ*N: requester i occupies bits `[i*N +: N]`
- `req_divisor` in NREQ*M: requester i occupies bits `[i*M +: M]`
- `req_ready` out NREQ: one-hot grant; a handshake is `req_valid[i] & req_ready[i]`
- `div_data_rdy` out 1: issue strobe to the divider
- `div_dividend` out N, `div_divisor` out M: operands to the divider
- `div_res_rdy` in 1, `div_merchant` in N, `div_remainder` in M: divider result
- `rsp_valid` out NREQ: one-hot, one-cycle response pulse
- `rsp_quot` out N, `rsp_rem` out M, `rsp_err` out 1: response payload, shared by all requesters
- `busy` out 1: any tag in flight or any response pending
- `sync_err` out 1: sticky; divider result missing when its tag expected one

## Operation
- Arbitration: round-robin pointer `last`, reset to NREQ-1.
  - Search starts at `last+1` mod NREQ; the first asserted `req_valid` wins.
  - `req_ready` is combinational from `req_valid`, `last` and `hold`; it is all-zero when `hold=1` or `rst=1`.
  - `last` updates only on a handshake.
- Issue register: on a handshake, the registered outputs load `div_data_rdy=1`, the winning operands, and a tag {valid, owner index, zero-div flag}. Otherwise `div_data_rdy=0`, and operands hold their previous value.
- Tag pipeline: `LAT` stages, shifting every cycle. The tag exiting the last stage aligns with the divider output for that operation.
- Response register, driven from the head tag:
  - Head valid and `div_res_rdy=1`: `rsp_valid[owner]=1`, `rsp_quot=div_merchant`, `rsp_rem=div_remainder`, `rsp_err=0`.
  - Head valid and `div_res_rdy=0`: response is still delivered with the divider data as sampled, `rsp_err=1`, and `sync_err` is set.
  - `div_res_rdy=1` with head invalid: the result is dropped silently. This covers stale divider results after reset.
- No response backpressure: requesters must accept `rsp_valid` in the cycle it is asserted.
- Payload outputs hold their last value when `rsp_valid=0`.
- `busy` = OR of tag valid bits, OR of `rsp_valid`, OR `div_data_rdy`.
- Reset (any cycle, including mid-operation) clears all of the following; in-flight operations are abandoned with no responses:
  - `last` = NREQ-1
  - `div_data_rdy`, operands, all tags = 0
  - `rsp_*` = 0, `sync_err` = 0
- `hold` asserted together with `req_valid`: no grant that cycle; `last` is unchanged.

## Timing
- Handshake in cycle t → `div_data_rdy` high in cycle t+1 → `div_res_rdy` expected in cycle t+1+LAT → `rsp_valid` high in cycle t+2+LAT. End-to-end latency is `LAT+2`.
- Throughput: one issue per cycle. With all requesters valid, grants rotate 0,1,…,NREQ-1,0 with no bubbles.
- Responses return in issue order; the owner of each is fixed by its tag.
- `sync_err` asserts the cycle after the mismatched head tag and stays set until `rst`.

## Configuration
- `DIV_ARB_ZERO_CHECK_EN` defined:
  - A granted request with divisor 0 is tagged zero-div, and `div_data_rdy` stays 0 for it; the divider is not used.
  - At the head, a zero-div tag produces a response at the same latency with `rsp_quot` all ones, `rsp_rem=0`, `rsp_err=1`. `div_res_rdy` is ignored for that slot.
- Macro undefined:
  - Divisor 0 is issued like any other request. The response carries the raw divider output with `rsp_err=0`, unless a sync mismatch sets it.
  - The zero-div tag bit is absent.

## Test plan
- Single op: requester 0 sends 13/3 at cycle 5 → `div_data_rdy` in cycle 6; `rsp_valid=01` in cycle 9 with quotient 4, remainder 1, `rsp_err=0`.
- Contention: both requesters continuously valid for 6 cycles (0 sends 20/3, 1 sends 7/2) → grants 0,1,0,1,0,1; responses alternate with quotient 6 rem 2 and quotient 3 rem 1, 4 cycles after each grant.
- Hold: assert `hold` for 3 cycles while requester 1 is valid → no grants and `busy` falls after drain; on release, requester 1 is granted first.
- Reset mid-flight: reset 1 cycle after two issues, and the divider model still returns 2 results → no `rsp_valid`, `sync_err=0`, `busy=0`.
- Sync fault: divider model suppresses `div_res_rdy` for one op → `rsp_err=1` on that response and `sync_err` stays 1 until reset.
- With `DIV_ARB_ZERO_CHECK_EN`: requester 1 sends 9/0 → `div_data_rdy` never pulses; `rsp_valid=10` 4 cycles after the grant with quotient 31, remainder 0, `rsp_err=1`.
